// File: rtl/pellet_map.sv
// -----------------------------------------------------------------------------
// pellet_map
//   Pellet-state store for the 28 x 36 tile playfield. After reset or a level
//   restart the block walks every tile through the external map lookup and
//   seeds a pellet on each eligible blank tile. It then accepts eat requests,
//   tracks the remaining pellet count, flags level clear and serves a
//   registered read port to the renderer.
//
// Ports
//   clk, rst          system clock, synchronous active-high reset
//   restart           level restart pulse, re-runs the seeding scan
//   q_x, q_y          tile pixel coordinates presented to the map lookup
//   grid_type         lookup answer for the coordinates of the previous cycle
//   eat_valid/col/row eat request from the movement logic
//   eat_ready         high while the block accepts eats (RUN)
//   eat_hit           one-cycle pulse, the accepted eat cleared a pellet
//   rd_col, rd_row    renderer read address
//   rd_pellet         registered pellet bit for the read address
//   pellets_left      remaining pellet count
//   init_done         high in RUN
//   level_clear       one-cycle pulse when the last pellet is eaten
// -----------------------------------------------------------------------------
module pellet_map #(
  parameter int TILE_SHIFT = 3,
  parameter int COLS       = 28,
  parameter int ROWS       = 36
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               restart,
  output logic signed [10:0] q_x,
  output logic signed [10:0] q_y,
  input  logic [5:0]         grid_type,
  input  logic               eat_valid,
  input  logic [4:0]         eat_col,
  input  logic [5:0]         eat_row,
  output logic               eat_ready,
  output logic               eat_hit,
  input  logic [4:0]         rd_col,
  input  logic [5:0]         rd_row,
  output logic               rd_pellet,
  output logic [9:0]         pellets_left,
  output logic               init_done,
  output logic               level_clear
);

  localparam int NTILES = COLS * ROWS;
  localparam logic [9:0] MAX_LEFT = 10'(NTILES);

  typedef enum logic {
    SCAN = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t              state_q;
  logic [4:0]          pres_col_q;    // tile currently on q_x/q_y
  logic [5:0]          pres_row_q;
  logic                pres_done_q;   // last tile has already been handed to pend
  logic [4:0]          pend_col_q;    // tile whose grid_type arrives this cycle
  logic [5:0]          pend_row_q;
  logic                pend_valid_q;
  logic [NTILES-1:0]   bits_q;
  logic [9:0]          left_q;
  logic                eat_hit_q;
  logic                level_clear_q;
  logic                rd_pellet_q;

  function automatic logic [9:0] tile_addr(input logic [5:0] row, input logic [4:0] col);
    return 10'(row) * 10'(COLS) + 10'(col);
  endfunction

  // Blank tiles inside the top/bottom margins get a pellet, except the
  // central band where only the two vertical corridors carry pellets.
  function automatic logic tile_eligible(input logic [5:0] gt, input logic [5:0] row,
                                         input logic [4:0] col);
    logic in_rows;
    logic in_band;
    logic corridor;
    in_rows  = (row >= 6'd4) && (row <= 6'd32);
    in_band  = (row >= 6'd12) && (row <= 6'd22);
    corridor = (col == 5'd6) || (col == 5'd21);
    return (gt == 6'd0) && in_rows && !(in_band && !corridor);
  endfunction

  logic [9:0] pend_addr;
  logic       pend_elig;
  logic       pend_last;
  logic       pres_last;
  logic [9:0] eat_addr;
  logic       eat_in_range;
  logic       eat_hit_d;
  logic [9:0] rd_addr;
  logic       rd_in_range;
  logic       rd_pellet_d;

  assign pend_addr = tile_addr(pend_row_q, pend_col_q);
  assign pend_elig = tile_eligible(grid_type, pend_row_q, pend_col_q);
  assign pend_last = (pend_row_q == 6'(ROWS - 1)) && (pend_col_q == 5'(COLS - 1));
  assign pres_last = (pres_row_q == 6'(ROWS - 1)) && (pres_col_q == 5'(COLS - 1));

  assign eat_addr     = tile_addr(eat_row, eat_col);
  assign eat_in_range = (eat_col < 5'(COLS)) && (eat_row < 6'(ROWS));
  assign eat_hit_d    = (state_q == RUN) && eat_valid && eat_in_range &&
                        bits_q[eat_addr] && (left_q != 10'd0);

  assign rd_addr     = tile_addr(rd_row, rd_col);
  assign rd_in_range = (rd_col < 5'(COLS)) && (rd_row < 6'(ROWS));
  // The map is only meaningful once seeding has finished.
  assign rd_pellet_d = (state_q == RUN) && rd_in_range && bits_q[rd_addr];

  always_ff @(posedge clk) begin
    eat_hit_q     <= 1'b0;
    level_clear_q <= 1'b0;
    if (rst || restart) begin
      // restart outranks any eat presented in the same cycle
      state_q      <= SCAN;
      pres_col_q   <= '0;
      pres_row_q   <= '0;
      pres_done_q  <= 1'b0;
      pend_col_q   <= '0;
      pend_row_q   <= '0;
      pend_valid_q <= 1'b0;
      bits_q       <= '0;
      left_q       <= '0;
      rd_pellet_q  <= 1'b0;
    end else begin
      rd_pellet_q <= rd_pellet_d;
      case (state_q)
        SCAN: begin
          // Stage 2: grid_type now answers the tile presented last cycle.
          if (pend_valid_q) begin
            bits_q[pend_addr] <= pend_elig;
            if (pend_elig && (left_q != MAX_LEFT)) begin
              left_q <= left_q + 10'd1;
            end
            if (pend_last) begin
              state_q <= RUN;
            end
          end
          // Stage 1: hand the presented tile to stage 2, advance row-major.
          pend_col_q   <= pres_col_q;
          pend_row_q   <= pres_row_q;
          pend_valid_q <= !pres_done_q;
          if (pres_last) begin
            pres_done_q <= 1'b1;   // q_x/q_y keep holding the last tile
          end else if (pres_col_q == 5'(COLS - 1)) begin
            pres_col_q <= '0;
            pres_row_q <= pres_row_q + 6'd1;
          end else begin
            pres_col_q <= pres_col_q + 5'd1;
          end
        end
        RUN: begin
          if (eat_hit_d) begin
            bits_q[eat_addr] <= 1'b0;
            left_q           <= left_q - 10'd1;
            eat_hit_q        <= 1'b1;
            level_clear_q    <= (left_q == 10'd1);
          end
        end
        default: state_q <= SCAN;
      endcase
    end
  end

  assign q_x          = $signed(11'(pres_col_q) << TILE_SHIFT);
  assign q_y          = $signed(11'(pres_row_q) << TILE_SHIFT);
  assign eat_ready    = (state_q == RUN);
  assign init_done    = (state_q == RUN);
  assign eat_hit      = eat_hit_q;
  assign level_clear  = level_clear_q;
  assign rd_pellet    = rd_pellet_q;
  assign pellets_left = left_q;

endmodule

// File: tb/tb_pellet_map.sv
// -----------------------------------------------------------------------------
// tb_pellet_map
//   Drives pellet_map with a registered model map lookup and compares every
//   observable output against a tile-array reference of the pellet rules.
// -----------------------------------------------------------------------------
module tb_pellet_map;

  logic               clk = 1'b0;
  logic               rst;
  logic               restart;
  logic signed [10:0] q_x;
  logic signed [10:0] q_y;
  logic [5:0]         grid_type;
  logic               eat_valid;
  logic [4:0]         eat_col;
  logic [5:0]         eat_row;
  logic               eat_ready;
  logic               eat_hit;
  logic [4:0]         rd_col;
  logic [5:0]         rd_row;
  logic               rd_pellet;
  logic [9:0]         pellets_left;
  logic               init_done;
  logic               level_clear;

  int total = 0;
  int bad   = 0;

  bit [5:0] map_gt   [0:35][0:27];
  bit       ref_bits [0:35][0:27];
  int       ref_left;

  always #5 clk = ~clk;

  pellet_map dut (
    .clk          (clk),
    .rst          (rst),
    .restart      (restart),
    .q_x          (q_x),
    .q_y          (q_y),
    .grid_type    (grid_type),
    .eat_valid    (eat_valid),
    .eat_col      (eat_col),
    .eat_row      (eat_row),
    .eat_ready    (eat_ready),
    .eat_hit      (eat_hit),
    .rd_col       (rd_col),
    .rd_row       (rd_row),
    .rd_pellet    (rd_pellet),
    .pellets_left (pellets_left),
    .init_done    (init_done),
    .level_clear  (level_clear)
  );

  // Map lookup with one cycle of latency: pixel -> tile by division by 8.
  function automatic logic [5:0] lookup(input logic signed [10:0] x, input logic signed [10:0] y);
    int c;
    int r;
    c = int'(x) / 8;
    r = int'(y) / 8;
    if (c < 0 || c > 27 || r < 0 || r > 35) return 6'h3f;
    return map_gt[r][c];
  endfunction

  always @(posedge clk) grid_type <= lookup(q_x, q_y);

  // Reference rule: blank, inside rows 4..32, and in rows 12..22 only on the
  // two corridor columns 6 and 21.
  function automatic bit eligible(input int c, input int r, input bit [5:0] gt);
    if (gt != 6'd0) return 1'b0;
    if (r < 4 || r > 32) return 1'b0;
    if (r >= 12 && r <= 22) return (c == 6 || c == 21);
    return 1'b1;
  endfunction

  function automatic bit in_range(input int c, input int r);
    return (c >= 0 && c < 28 && r >= 0 && r < 36);
  endfunction

  task automatic build_ref();
    ref_left = 0;
    for (int r = 0; r < 36; r++) begin
      for (int c = 0; c < 28; c++) begin
        ref_bits[r][c] = eligible(c, r, map_gt[r][c]);
        if (ref_bits[r][c]) ref_left++;
      end
    end
  endtask

  task automatic load_random_map();
    for (int r = 0; r < 36; r++)
      for (int c = 0; c < 28; c++)
        map_gt[r][c] = ($urandom_range(0, 9) < 6) ? 6'd0 : 6'($urandom_range(1, 63));
    map_gt[4][1]  = 6'd0;
    map_gt[4][0]  = 6'd5;
    map_gt[4][13] = 6'd7;
    map_gt[2][1]  = 6'd0;
    map_gt[33][1] = 6'd0;
    map_gt[17][3] = 6'd0;
    build_ref();
  endtask

  // Walls everywhere except one eligible blank and some ineligible blanks.
  task automatic load_single_map();
    for (int r = 0; r < 36; r++)
      for (int c = 0; c < 28; c++)
        map_gt[r][c] = 6'($urandom_range(1, 63));
    for (int c = 0; c < 28; c++) map_gt[0][c] = 6'd0;
    map_gt[5][2]  = 6'd0;
    map_gt[17][3] = 6'd0;
    map_gt[35][9] = 6'd0;
    map_gt[33][1] = 6'd0;
    build_ref();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_init(output int n);
    n = 0;
    while (!init_done && n < 1200) begin
      step();
      n++;
    end
  endtask

  task automatic read_tile(input int c, input int r, input bit exp);
    rd_col = 5'(c);
    rd_row = 6'(r);
    step();
    chk($sformatf("rd(%0d,%0d)", c, r), rd_pellet, exp);
  endtask

  // One eat with a simultaneous read; the caller decides when eat_valid drops.
  task automatic eat_tx(input int c, input int r, input int rc, input int rr);
    bit exp_hit;
    bit exp_rd;
    bit exp_clear;
    eat_valid = 1'b1;
    eat_col   = 5'(c);
    eat_row   = 6'(r);
    rd_col    = 5'(rc);
    rd_row    = 6'(rr);
    exp_rd    = in_range(rc, rr) ? ref_bits[rr][rc] : 1'b0;
    exp_hit   = in_range(c, r) ? ref_bits[r][c] : 1'b0;
    exp_clear = exp_hit && (ref_left == 1);
    if (exp_hit) begin
      ref_bits[r][c] = 1'b0;
      ref_left--;
    end
    step();
    chk("eat_hit", eat_hit, exp_hit);
    chk("level_clear", level_clear, exp_clear);
    chk("pellets_left", pellets_left, ref_left);
    chk("rd_same_cycle", rd_pellet, exp_rd);
    $display("eat col=%0d row=%0d hit=%0d left=%0d clear=%0d", c, r, eat_hit, pellets_left,
             level_clear);
  endtask

  initial begin
    int n;
    rst = 1'b1; restart = 1'b0; eat_valid = 1'b0; eat_col = '0; eat_row = '0;
    rd_col = '0; rd_row = '0;
    load_random_map();
    step();
    step();
    chk("rst_q_x", q_x, 0);
    chk("rst_q_y", q_y, 0);
    chk("rst_eat_ready", eat_ready, 0);
    chk("rst_eat_hit", eat_hit, 0);
    chk("rst_rd_pellet", rd_pellet, 0);
    chk("rst_left", pellets_left, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_level_clear", level_clear, 0);

    // Seeding scan with a random map.
    rst = 1'b0;
    wait_init(n);
    chk("init_latency", n, 1009);
    $display("scan done cycles=%0d left=%0d model=%0d", n, pellets_left, ref_left);
    chk("scan_left", pellets_left, ref_left);
    chk("eat_ready_run", eat_ready, 1);
    chk("q_x_last", q_x, 27 * 8);
    chk("q_y_last", q_y, 35 * 8);
    read_tile(1, 4, 1'b1);
    read_tile(0, 4, 1'b0);
    read_tile(13, 4, 1'b0);
    read_tile(1, 2, 1'b0);
    read_tile(1, 33, 1'b0);
    read_tile(3, 17, 1'b0);
    read_tile(30, 10, 1'b0);
    read_tile(5, 40, 1'b0);
    for (int r = 0; r < 36; r++)
      for (int c = 0; c < 28; c++)
        read_tile(c, r, ref_bits[r][c]);
    $display("read sweep done checks=%0d", total);

    // Restart beats a same-cycle eat and reseeds the map.
    restart = 1'b1; eat_valid = 1'b1; eat_col = 5'd1; eat_row = 6'd4;
    rd_col = 5'd1; rd_row = 6'd4;
    step();
    restart = 1'b0; eat_valid = 1'b0;
    chk("restart_eat_hit", eat_hit, 0);
    chk("restart_init_done", init_done, 0);
    chk("restart_eat_ready", eat_ready, 0);
    chk("restart_left", pellets_left, 0);
    wait_init(n);
    chk("restart_latency", n, 1009);
    chk("restart_left_reseed", pellets_left, ref_left);
    read_tile(1, 4, 1'b1);
    $display("restart rescan cycles=%0d left=%0d", n, pellets_left);

    // Directed eats.
    eat_tx(1, 4, 1, 4);
    eat_valid = 1'b0;
    read_tile(1, 4, 1'b0);
    eat_tx(1, 4, 0, 0);
    eat_tx(0, 4, 0, 0);
    eat_tx(30, 40, 0, 0);
    eat_valid = 1'b0;
    step();
    chk("eat_hit_idle", eat_hit, 0);

    // Back-to-back random eats, reads mostly on the eaten tile.
    for (int i = 0; i < 80; i++) begin
      int c;
      int r;
      c = ($urandom_range(0, 15) == 0) ? int'($urandom_range(28, 31)) : int'($urandom_range(0, 27));
      r = ($urandom_range(0, 15) == 0) ? int'($urandom_range(36, 63)) : int'($urandom_range(4, 32));
      if ($urandom_range(0, 1) == 0) eat_tx(c, r, c, r);
      else eat_tx(c, r, int'($urandom_range(0, 27)), int'($urandom_range(0, 35)));
    end
    eat_valid = 1'b0;
    step();

    // Mid-scan reset with a single-pellet map; eats held during scan.
    load_single_map();
    rst = 1'b1;
    step();
    rst = 1'b0;
    eat_valid = 1'b1; eat_col = 5'd2; eat_row = 6'd5; rd_col = 5'd2; rd_row = 6'd5;
    for (int i = 0; i < 500; i++) step();
    chk("scan_rd_zero", rd_pellet, 0);
    chk("scan_eat_ready", eat_ready, 0);
    rst = 1'b1;
    step();
    chk("midrst_q_x", q_x, 0);
    chk("midrst_q_y", q_y, 0);
    chk("midrst_eat_ready", eat_ready, 0);
    chk("midrst_eat_hit", eat_hit, 0);
    chk("midrst_rd_pellet", rd_pellet, 0);
    chk("midrst_left", pellets_left, 0);
    chk("midrst_init_done", init_done, 0);
    chk("midrst_level_clear", level_clear, 0);
    rst = 1'b0;
    wait_init(n);
    eat_valid = 1'b0;
    chk("midrst_latency", n, 1009);
    chk("single_left", pellets_left, 1);
    chk("single_left_model", pellets_left, ref_left);
    $display("single map scan cycles=%0d left=%0d", n, pellets_left);

    // Last pellet: level_clear coincides with eat_hit, then both drop.
    eat_tx(2, 5, 2, 5);
    eat_valid = 1'b0;
    step();
    chk("clear_pulse_end", level_clear, 0);
    chk("hit_pulse_end", eat_hit, 0);
    chk("still_run", init_done, 1);
    eat_tx(2, 5, 2, 5);
    eat_valid = 1'b0;
    step();
    chk("left_no_underflow", pellets_left, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
